// File: rtl/sd4_pp_serial.sv
// Nine-lane 8x8 signed multiplier, radix-4 (SD4) recoded, one digit per cycle over four cycles.
// Optional build macro SD4_ZERO_SKIP_EN: all-zero weights bypass CALC and finish in one edge.
module sd4_pp_serial #(
   parameter int unsigned HOLD_OUTPUTS = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic signed [7:0]  act_0,
   input  logic signed [7:0]  act_1,
   input  logic signed [7:0]  act_2,
   input  logic signed [7:0]  act_3,
   input  logic signed [7:0]  act_4,
   input  logic signed [7:0]  act_5,
   input  logic signed [7:0]  act_6,
   input  logic signed [7:0]  act_7,
   input  logic signed [7:0]  act_8,
   input  logic signed [7:0]  wgt_0,
   input  logic signed [7:0]  wgt_1,
   input  logic signed [7:0]  wgt_2,
   input  logic signed [7:0]  wgt_3,
   input  logic signed [7:0]  wgt_4,
   input  logic signed [7:0]  wgt_5,
   input  logic signed [7:0]  wgt_6,
   input  logic signed [7:0]  wgt_7,
   input  logic signed [7:0]  wgt_8,
   output logic signed [15:0] aligned_pp_0,
   output logic signed [15:0] aligned_pp_1,
   output logic signed [15:0] aligned_pp_2,
   output logic signed [15:0] aligned_pp_3,
   output logic signed [15:0] aligned_pp_4,
   output logic signed [15:0] aligned_pp_5,
   output logic signed [15:0] aligned_pp_6,
   output logic signed [15:0] aligned_pp_7,
   output logic signed [15:0] aligned_pp_8,
   output logic               pp_valid,
   output logic               busy
);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e             state_q, state_d;
   logic [1:0]         cnt_q, cnt_d;
   logic signed [7:0]  act_in [9];
   logic signed [7:0]  wgt_in [9];
   logic signed [7:0]  act_q [9];
   logic signed [7:0]  act_d [9];
   logic signed [7:0]  wgt_q [9];
   logic signed [7:0]  wgt_d [9];
   logic signed [15:0] acc_q [9];
   logic signed [15:0] acc_d [9];
   logic signed [15:0] pp_q [9];
   logic signed [15:0] pp_d [9];
   logic signed [15:0] term [9];
`ifdef SD4_ZERO_SKIP_EN
   logic               all_zero;
`endif

   assign act_in = '{act_0, act_1, act_2, act_3, act_4, act_5, act_6, act_7, act_8};
   assign wgt_in = '{wgt_0, wgt_1, wgt_2, wgt_3, wgt_4, wgt_5, wgt_6, wgt_7, wgt_8};

   // Digit d uses weight bits {2d+1, 2d, 2d-1}; appending a zero LSB supplies bit -1.
   function automatic logic signed [15:0] sd4_term(input logic signed [7:0] a,
                                                   input logic [7:0] w,
                                                   input logic [1:0] d);
      logic [8:0]         wext;
      logic [2:0]         trip;
      logic signed [15:0] a16;
      logic signed [15:0] m;
      wext = {w, 1'b0};
      trip = 3'(wext >> {d, 1'b0});
      a16  = {{8{a[7]}}, a};
      case (trip)
         3'b001, 3'b010: m = a16;
         3'b011:         m = a16 <<< 1;
         3'b100:         m = -(a16 <<< 1);
         3'b101, 3'b110: m = -a16;
         default:        m = '0;
      endcase
      return m <<< {d, 1'b0};
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      act_d   = act_q;
      wgt_d   = wgt_q;
      acc_d   = acc_q;
      pp_d    = pp_q;
      for (int i = 0; i < 9; i++) begin
         term[i] = sd4_term(act_q[i], wgt_q[i], cnt_q);
      end
`ifdef SD4_ZERO_SKIP_EN
      all_zero = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (wgt_in[i] != 8'sd0) all_zero = 1'b0;
      end
`endif
      case (state_q)
         StIdle: begin
            if (start) begin
               act_d   = act_in;
               wgt_d   = wgt_in;
               cnt_d   = 2'd0;
               state_d = StCalc;
               for (int i = 0; i < 9; i++) acc_d[i] = '0;
`ifdef SD4_ZERO_SKIP_EN
               if (all_zero) begin
                  state_d = StDone;
                  for (int i = 0; i < 9; i++) pp_d[i] = '0;
               end
`endif
            end
         end
         StCalc: begin
            cnt_d = cnt_q + 2'd1;
            for (int i = 0; i < 9; i++) acc_d[i] = acc_q[i] + term[i];
            if (cnt_q == 2'd3) begin
               state_d = StDone;
               for (int i = 0; i < 9; i++) pp_d[i] = acc_q[i] + term[i];
            end
         end
         StDone: begin
            state_d = StIdle;
            if (HOLD_OUTPUTS == 0) begin
               for (int i = 0; i < 9; i++) pp_d[i] = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 2'd0;
         for (int i = 0; i < 9; i++) begin
            act_q[i] <= '0;
            wgt_q[i] <= '0;
            acc_q[i] <= '0;
            pp_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         act_q   <= act_d;
         wgt_q   <= wgt_d;
         acc_q   <= acc_d;
         pp_q    <= pp_d;
      end
   end

   assign aligned_pp_0 = pp_q[0];
   assign aligned_pp_1 = pp_q[1];
   assign aligned_pp_2 = pp_q[2];
   assign aligned_pp_3 = pp_q[3];
   assign aligned_pp_4 = pp_q[4];
   assign aligned_pp_5 = pp_q[5];
   assign aligned_pp_6 = pp_q[6];
   assign aligned_pp_7 = pp_q[7];
   assign aligned_pp_8 = pp_q[8];
   assign pp_valid     = (state_q == StDone);
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_sd4_pp_serial.sv
// Bench for sd4_pp_serial: two instances (HOLD_OUTPUTS 1 and 0) share stimulus; a queue of
// expected products is filled at start and drained when pp_valid is seen.
module tb_sd4_pp_serial;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic signed [7:0]  act [9];
   logic signed [7:0]  wgt [9];
   logic signed [15:0] pp_h [9];
   logic signed [15:0] pp_z [9];
   logic               pv_h, pv_z, busy_h, busy_z;
   logic [143:0]       sb [$];
   int                 checks = 0;
   int                 errors = 0;

`ifdef SD4_ZERO_SKIP_EN
   localparam int ZeroLat = 1;
`else
   localparam int ZeroLat = 5;
`endif

   always #5 clk = ~clk;

   sd4_pp_serial #(.HOLD_OUTPUTS(1)) u_dut_hold (
      .clk(clk), .rst(rst), .start(start),
      .act_0(act[0]), .act_1(act[1]), .act_2(act[2]), .act_3(act[3]), .act_4(act[4]),
      .act_5(act[5]), .act_6(act[6]), .act_7(act[7]), .act_8(act[8]),
      .wgt_0(wgt[0]), .wgt_1(wgt[1]), .wgt_2(wgt[2]), .wgt_3(wgt[3]), .wgt_4(wgt[4]),
      .wgt_5(wgt[5]), .wgt_6(wgt[6]), .wgt_7(wgt[7]), .wgt_8(wgt[8]),
      .aligned_pp_0(pp_h[0]), .aligned_pp_1(pp_h[1]), .aligned_pp_2(pp_h[2]),
      .aligned_pp_3(pp_h[3]), .aligned_pp_4(pp_h[4]), .aligned_pp_5(pp_h[5]),
      .aligned_pp_6(pp_h[6]), .aligned_pp_7(pp_h[7]), .aligned_pp_8(pp_h[8]),
      .pp_valid(pv_h), .busy(busy_h)
   );

   sd4_pp_serial #(.HOLD_OUTPUTS(0)) u_dut_clr (
      .clk(clk), .rst(rst), .start(start),
      .act_0(act[0]), .act_1(act[1]), .act_2(act[2]), .act_3(act[3]), .act_4(act[4]),
      .act_5(act[5]), .act_6(act[6]), .act_7(act[7]), .act_8(act[8]),
      .wgt_0(wgt[0]), .wgt_1(wgt[1]), .wgt_2(wgt[2]), .wgt_3(wgt[3]), .wgt_4(wgt[4]),
      .wgt_5(wgt[5]), .wgt_6(wgt[6]), .wgt_7(wgt[7]), .wgt_8(wgt[8]),
      .aligned_pp_0(pp_z[0]), .aligned_pp_1(pp_z[1]), .aligned_pp_2(pp_z[2]),
      .aligned_pp_3(pp_z[3]), .aligned_pp_4(pp_z[4]), .aligned_pp_5(pp_z[5]),
      .aligned_pp_6(pp_z[6]), .aligned_pp_7(pp_z[7]), .aligned_pp_8(pp_z[8]),
      .pp_valid(pv_z), .busy(busy_z)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pushes the behavioural products of the current operands and pulses start for one edge.
   task automatic issue();
      logic [143:0]       e;
      logic signed [15:0] p;
      for (int i = 0; i < 9; i++) begin
         p = act[i] * wgt[i];
         e[16*i +: 16] = p;
      end
      sb.push_back(e);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Edges counted from the start-accepting edge (which counts as 1).
   task automatic wait_valid(output int lat);
      lat = 1;
      while (pv_h !== 1'b1 && lat < 30) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         act[i] = '0;
         wgt[i] = '0;
      end
      #3;
      checks++;
      if ({pv_h, busy_h, pv_z, busy_z} !== 4'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 0000", {pv_h, busy_h, pv_z, busy_z});
      end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (pp_h[i] !== 16'sd0 || pp_z[i] !== 16'sd0) begin
            errors++;
            $display("FAIL reset_pp lane %0d: got %0d/%0d required 0", i, pp_h[i], pp_z[i]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int           lat;
      logic [143:0] e;
      for (int i = 0; i < 9; i++) begin
         act[i] = 8'sd3;
         wgt[i] = 8'sd5;
      end
      issue();
      checks++;
      if (busy_h !== 1'b1 || pv_h !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy_start: busy=%b pv=%b required busy=1 pv=0", busy_h, pv_h);
      end
      wait_valid(lat);
      checks++;
      if (lat != 5 || pv_z !== 1'b1 || busy_h !== 1'b1) begin
         errors++;
         $display("FAIL basic_latency: got %0d pv_z=%b busy=%b required 5/1/1", lat, pv_z, busy_h);
      end
      e = sb.pop_front();
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (pp_h[i] !== 16'sd15 || pp_z[i] !== 16'sd15 || $signed(e[16*i +: 16]) != 16'sd15) begin
            errors++;
            $display("FAIL basic_pp lane %0d: got %0d/%0d required 15", i, pp_h[i], pp_z[i]);
         end
      end
      tick();
      checks++;
      if (pv_h !== 1'b0 || busy_h !== 1'b0 || busy_z !== 1'b0) begin
         errors++;
         $display("FAIL basic_after: pv=%b busy=%b required 0/0", pv_h, busy_h);
      end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (pp_h[i] !== 16'sd15 || pp_z[i] !== 16'sd0) begin
            errors++;
            $display("FAIL basic_hold lane %0d: got %0d/%0d required 15/0", i, pp_h[i], pp_z[i]);
         end
      end
   endtask

   task automatic test_corners();
      int           ca [9] = '{-128, 127, -128, 127, -1, 0, -5, 85, 1};
      int           cw [9] = '{-128, -128, 127, 127, -1, -77, 6, -86, 1};
      int           cp [9] = '{16384, -16256, -16256, 16129, 1, 0, -30, -7310, 1};
      int           lat;
      logic [143:0] e;
      for (int i = 0; i < 9; i++) begin
         act[i] = 8'(ca[i]);
         wgt[i] = 8'(cw[i]);
      end
      issue();
      wait_valid(lat);
      checks++;
      if (lat != 5) begin
         errors++;
         $display("FAIL corner_latency: got %0d required 5", lat);
      end
      e = sb.pop_front();
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (pp_h[i] !== 16'(cp[i]) || pp_z[i] !== 16'(cp[i])) begin
            errors++;
            $display("FAIL corner_pp lane %0d: got %0d/%0d required %0d (model %0d)",
                     i, pp_h[i], pp_z[i], cp[i], $signed(e[16*i +: 16]));
         end
      end
      tick();
   endtask

   task automatic test_restart_ignored();
      logic [143:0] e;
      int           npv;
      for (int i = 0; i < 9; i++) begin
         act[i] = 8'(i * 7 - 20);
         wgt[i] = 8'(33 - i * 9);
      end
      issue();
      npv = 0;
      tick();
      for (int i = 0; i < 9; i++) begin
         act[i] = 8'(100 - i);
         wgt[i] = 8'(-50 + i);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      npv += int'(pv_h);
      e = sb.pop_front();
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (pp_h[i] !== $signed(e[16*i +: 16]) || pp_z[i] !== $signed(e[16*i +: 16])) begin
            errors++;
            $display("FAIL restart_pp lane %0d: got %0d/%0d required %0d",
                     i, pp_h[i], pp_z[i], $signed(e[16*i +: 16]));
         end
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         npv += int'(pv_h);
         tick();
      end
      checks++;
      if (npv != 1 || busy_h !== 1'b0) begin
         errors++;
         $display("FAIL restart_pulses: got %0d busy=%b required 1/0", npv, busy_h);
      end
   endtask

   task automatic test_abort();
      int           lat;
      int           npv;
      logic [143:0] e;
      for (int i = 0; i < 9; i++) begin
         act[i] = 8'(-3 * i - 1);
         wgt[i] = 8'(11 * i + 2);
      end
      issue();
      tick();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({pv_h, busy_h, pv_z, busy_z} !== 4'b0) begin
         errors++;
         $display("FAIL abort_ctrl: got %b required 0000", {pv_h, busy_h, pv_z, busy_z});
      end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (pp_h[i] !== 16'sd0 || pp_z[i] !== 16'sd0) begin
            errors++;
            $display("FAIL abort_pp lane %0d: got %0d/%0d required 0", i, pp_h[i], pp_z[i]);
         end
      end
      tick();
      rst = 1'b0;
      void'(sb.pop_back());
      npv = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         npv += int'(pv_h | pv_z);
      end
      checks++;
      if (npv != 0) begin
         errors++;
         $display("FAIL abort_no_valid: got %0d pulses required 0", npv);
      end
      for (int i = 0; i < 9; i++) begin
         act[i] = 8'(i * 13 - 60);
         wgt[i] = 8'(77 - i * 17);
      end
      issue();
      wait_valid(lat);
      checks++;
      if (lat != 5) begin
         errors++;
         $display("FAIL abort_restart_latency: got %0d required 5", lat);
      end
      e = sb.pop_front();
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (pp_h[i] !== $signed(e[16*i +: 16]) || pp_z[i] !== $signed(e[16*i +: 16])) begin
            errors++;
            $display("FAIL abort_restart_pp lane %0d: got %0d/%0d required %0d",
                     i, pp_h[i], pp_z[i], $signed(e[16*i +: 16]));
         end
      end
      tick();
   endtask

   task automatic test_zero_weights();
      int           lat;
      logic [143:0] e;
      for (int i = 0; i < 9; i++) begin
         act[i] = 8'(i * 19 + 5);
         wgt[i] = '0;
      end
      issue();
      wait_valid(lat);
      checks++;
      if (lat != ZeroLat || pv_z !== 1'b1) begin
         errors++;
         $display("FAIL zero_latency: got %0d required %0d", lat, ZeroLat);
      end
      e = sb.pop_front();
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (pp_h[i] !== 16'sd0 || pp_z[i] !== 16'sd0 || e[16*i +: 16] != 16'd0) begin
            errors++;
            $display("FAIL zero_pp lane %0d: got %0d/%0d required 0", i, pp_h[i], pp_z[i]);
         end
      end
      tick();
      checks++;
      if (pv_h !== 1'b0 || busy_h !== 1'b0) begin
         errors++;
         $display("FAIL zero_after: pv=%b busy=%b required 0/0", pv_h, busy_h);
      end
   endtask

   task automatic test_random(input int n);
      int           lat;
      int           bad;
      logic [143:0] e;
      logic         allz;
      for (int k = 0; k < n; k++) begin
         allz = 1'b1;
         for (int i = 0; i < 9; i++) begin
            act[i] = 8'($urandom);
            wgt[i] = ($urandom_range(0, 15) == 0) ? 8'sd0 : 8'($urandom);
            if (wgt[i] != 8'sd0) allz = 1'b0;
         end
         issue();
         wait_valid(lat);
         checks++;
         if (lat != (allz ? ZeroLat : 5)) begin
            errors++;
            $display("FAIL rand_latency op %0d: got %0d required %0d", k, lat, allz ? ZeroLat : 5);
         end
         e = sb.pop_front();
         bad = 0;
         for (int i = 0; i < 9; i++) begin
            if (pp_h[i] !== $signed(e[16*i +: 16]) || pp_z[i] !== $signed(e[16*i +: 16])) bad++;
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL rand_pp op %0d: %0d lanes differ, lane0 got %0d/%0d required %0d",
                     k, bad, pp_h[0], pp_z[0], $signed(e[15:0]));
         end
         tick();
         bad = 0;
         for (int i = 0; i < 9; i++) begin
            if (pp_h[i] !== $signed(e[16*i +: 16]) || pp_z[i] !== 16'sd0) bad++;
         end
         checks++;
         if (bad != 0 || pv_h !== 1'b0 || busy_h !== 1'b0) begin
            errors++;
            $display("FAIL rand_idle op %0d: %0d lanes differ pv=%b busy=%b", k, bad, pv_h, busy_h);
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got %0d entries required 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corners();
      test_restart_ignored();
      test_abort();
      test_zero_weights();
      test_random(2000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
